// File: rtl/led_chase_ctrl_pkg.sv
// led_chase_ctrl_pkg: shared mode/state encodings and default animation tap bits.
package led_chase_ctrl_pkg;
  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_LOW    = 2'b01;
  localparam logic [1:0] MODE_NORMAL = 2'b10;
  localparam logic [1:0] MODE_HIGH   = 2'b11;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, BLINK} state_e;
  localparam int TAP_LOW_DEF    = 21;
  localparam int TAP_NORMAL_DEF = 20;
  localparam int TAP_HIGH_DEF   = 19;
endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: prescale counter with selectable tap and registered one-cycle tick.
module led_tick_gen #(
  parameter int CNT_W = 22,
  parameter int TW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv_i,
  input  logic          clr_i,
  input  logic [TW-1:0] tap_i,
  output logic          hit_o,
  output logic          tick_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d, mask;
  logic tick_q;
  // mask covers counter bits [tap:0]
  assign mask = {CNT_W{1'b1}} >> (TW'(CNT_W - 1) - tap_i);
  assign hit_o = adv_i && !clr_i && ((cnt_q & mask) == mask);
  assign cnt_d = clr_i ? '0 : adv_i ? cnt_q + 1'b1 : cnt_q;
  assign tick_o = tick_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= hit_o;
    end
  end
endmodule

// File: rtl/led_chase_ctrl.sv
// led_chase_ctrl: power-mode paced LED chase while cooking, completion blink on done.
module led_chase_ctrl
  import led_chase_ctrl_pkg::*;
#(
  parameter int N_LEDS      = 8,
  parameter int CNT_W       = 22,
  parameter int TAP_LOW     = TAP_LOW_DEF,
  parameter int TAP_NORMAL  = TAP_NORMAL_DEF,
  parameter int TAP_HIGH    = TAP_HIGH_DEF,
  parameter int BLINK_TICKS = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              run,
  input  logic              done,
  output logic [N_LEDS-1:0] leds,
  output logic              tick,
  output logic              busy
);
  localparam int TW = $clog2(CNT_W);
  localparam int BW = $clog2(BLINK_TICKS + 1);
  state_e state_q, state_d;
  logic [N_LEDS-1:0] leds_q, leds_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [1:0] mode_q;
  logic [TW-1:0] tap;
  logic go, off, last, adv, clr, hit;
  assign go   = run && (mode != MODE_OFF);
  assign off  = mode == MODE_OFF;
  assign last = blink_q == BW'(BLINK_TICKS - 1);
  led_tick_gen #(.CNT_W(CNT_W), .TW(TW)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .adv_i  (adv),
    .clr_i  (clr),
    .tap_i  (tap),
    .hit_o  (hit),
    .tick_o (tick)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      leds_q  <= '0;
      blink_q <= '0;
      mode_q  <= MODE_OFF;
    end else begin
      state_q <= state_d;
      leds_q  <= leds_d;
      blink_q <= blink_d;
      mode_q  <= mode;
    end
  end
  // done outranks mode-off, which outranks run
  always_comb begin
    state_d = state_q;
    if (done) state_d = BLINK;
    else
      case (state_q)
        IDLE:    state_d = go ? RUN : IDLE;
        RUN:     state_d = off ? IDLE : !run ? PAUSE : RUN;
        PAUSE:   state_d = off ? IDLE : run ? RUN : PAUSE;
        BLINK:   state_d = (hit && last) ? IDLE : BLINK;
        default: state_d = IDLE;
      endcase
  end
  always_comb begin
    adv = (state_q == RUN) || (state_q == BLINK);
    clr = done || ((state_q == IDLE) && go) || ((state_q == RUN) && (mode != mode_q));
    tap = (state_q == BLINK)  ? TW'(TAP_NORMAL) :
          (mode == MODE_LOW)  ? TW'(TAP_LOW) :
          (mode == MODE_HIGH) ? TW'(TAP_HIGH) : TW'(TAP_NORMAL);
    leds_d = done                                          ? '1 :
             (state_d == IDLE)                             ? '0 :
             (state_q == IDLE)                             ? N_LEDS'(1) :
             (state_q == RUN && state_d == RUN && hit)     ? {leds_q[N_LEDS-2:0], leds_q[N_LEDS-1]} :
             (state_q == BLINK && hit)                     ? ~leds_q : leds_q;
    blink_d = done ? '0 : (state_q == BLINK && hit) ? blink_q + 1'b1 : blink_q;
  end
  assign leds = leds_q;
  assign busy = state_q != IDLE;
endmodule

// File: doc/led_chase_ctrl.md
Name: led_chase_ctrl

Overview:
- Parametrised successor to the power-mode LED rate selector.
- Owns a free-running prescale counter and derives a one-cycle animation tick whose period follows the cooking power mode.
- Drives an N-LED rotating chase while cooking runs, and a completion blink sequence when the timer signals done.
- Sits between the microwave control FSM (run, done, mode) and the board LEDs.

Parameters:
- N_LEDS, 8: number of LEDs driven; must be >= 2.
- CNT_W, 22: prescale counter width.
- TAP_LOW, 21: tap bit used for mode 2'b01 (slowest); must be < CNT_W.
- TAP_NORMAL, 20: tap bit used for mode 2'b10, and for all blink timing.
- TAP_HIGH, 19: tap bit used for mode 2'b11 (fastest).
- BLINK_TICKS, 6: number of ticks in the completion blink; must be >= 1.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- mode, input, 2: power mode; 00 = off, 01 = low, 10 = normal, 11 = high.
- run, input, 1: level; cooking is active.
- done, input, 1: single-cycle pulse; cook cycle finished.
- leds, output, N_LEDS: LED drive, 1 = lit.
- tick, output, 1: one-cycle animation strobe, registered.
- busy, output, 1: high in RUN, PAUSE and BLINK.

Behaviour:
- Reset values: leds = 0, tick = 0, busy = 0, counter = 0, blink_cnt = 0, mode_q = 0, state = IDLE.
- Tap selection: tap = TAP_LOW / TAP_NORMAL / TAP_HIGH for modes 01 / 10 / 11. In BLINK the tap is always TAP_NORMAL.
- Counter: increments by 1 each cycle in RUN and BLINK, wraps modulo 2^CNT_W. It holds in IDLE and PAUSE.
- Tick generation:
  - The tick condition is true in a cycle where the counter is advancing and counter[tap:0] is all ones.
  - The tick is registered, so it appears one cycle after that condition.
  - Tick period = 2^(tap+1) clocks. The first tick after a counter clear arrives 2^(tap+1) cycles after the clear.
- mode_q registers mode every cycle. When mode differs from mode_q in RUN:
  - the counter is cleared that cycle;
  - no tick is produced;
  - the LED position is kept.
- Event priority, highest first: rst > done > (mode == 00) > run.
- State transitions:
  - IDLE: leds = 0. If run && mode != 00, go to RUN with leds = 1 (bit 0) and counter = 0.
  - RUN: each tick rotates leds left by one; bit N_LEDS-1 wraps to bit 0. If run = 0, go to PAUSE. If mode = 00, go to IDLE with leds = 0.
  - PAUSE: leds and counter hold. If run && mode != 00, return to RUN and resume the counter without clearing it. If mode = 00, go to IDLE with leds = 0.
  - BLINK:
    - Entry happens on a done pulse from any state, including BLINK itself, which restarts the sequence.
    - On entry: leds = all ones, counter = 0, blink_cnt = 0.
    - Each tick inverts leds and increments blink_cnt.
    - On the tick where blink_cnt == BLINK_TICKS-1, go to IDLE with leds = 0 instead of inverting.
    - run and mode are ignored in BLINK.
- Simultaneous events:
  - done together with a mode change: done wins.
  - rst together with done: reset wins.
- busy = (state != IDLE), registered with the state.
- Reset mid-operation: all state and outputs return to reset values on the next edge; no residual tick.

Decomposition:
- Shared package holds:
  - the mode encodings MODE_OFF, MODE_LOW, MODE_NORMAL, MODE_HIGH;
  - the state encoding (IDLE, RUN, PAUSE, BLINK);
  - the default tap constants 21/20/19, so other rate users stay consistent.
- One sub-module is natural: led_tick_gen (counter, tap mux, clear/hold controls, registered tick output). The state machine and LED register stay in led_chase_ctrl.

Test Plan:
Bench parameters: N_LEDS=4, CNT_W=6, TAP_LOW=3, TAP_NORMAL=2, TAP_HIGH=1, BLINK_TICKS=4.
- Run at normal rate: rst, then mode=10 and run=1 → leds = 0001 the next cycle; then 0010, 0100, 1000, 0001, with ticks 8 cycles apart; busy = 1.
- Mode rates: repeat with mode=11 → tick spacing 4 cycles; mode=01 → spacing 16 cycles.
- Pause and resume: drop run mid-period for 20 cycles → leds frozen and tick = 0. Raise run → the next tick arrives after the remaining part of the period, with no counter clear.
- Mode change mid-run: at leds = 0100, switch mode 10→11 → counter cleared, leds held at 0100, next tick 4 cycles later.
- Completion blink: done pulse during RUN → leds = 1111, then 0000, 1111, 0000 on ticks 8 cycles apart; on the 4th tick leds = 0000 and busy = 0. A second done during the blink restarts the sequence at 1111.
- Priority and reset: mode=00 in RUN → IDLE with leds = 0. Done and mode=00 in the same cycle → BLINK. rst during BLINK → all outputs 0 the next cycle.
